// File: rtl/lsu_store_buffer_if.sv
// Pipeline request/response and data-cache port bundle for the LSU store buffer.
// The slave modport is the store buffer; master is the pipeline/cache side.
interface lsu_store_buffer_if #(
   parameter int unsigned SB_PTR_W = 2
);
   logic              req_valid;
   logic              req_ready;
   logic              req_store;
   logic [31:0]       req_addr;
   logic [31:0]       req_wdata;
   logic              resp_valid;
   logic [31:0]       resp_data;
   logic              flush;
   logic              flush_done;
   logic [SB_PTR_W:0] sb_count;
   logic [31:0]       c_read_ptr;
   logic [31:0]       c_read_value;
   logic              c_read_success;
   logic              c_write_enable;
   logic [31:0]       c_write_ptr;
   logic [31:0]       c_write_value;
   logic              c_write_success;
   logic              c_all_write_back;
   logic              c_all_write_back_success;

   modport slave (
      input  req_valid, req_store, req_addr, req_wdata, flush,
             c_read_value, c_read_success, c_write_success, c_all_write_back_success,
      output req_ready, resp_valid, resp_data, flush_done, sb_count,
             c_read_ptr, c_write_enable, c_write_ptr, c_write_value, c_all_write_back
   );

   modport master (
      output req_valid, req_store, req_addr, req_wdata, flush,
             c_read_value, c_read_success, c_write_success, c_all_write_back_success,
      input  req_ready, resp_valid, resp_data, flush_done, sb_count,
             c_read_ptr, c_write_enable, c_write_ptr, c_write_value, c_all_write_back
   );
endinterface

// File: rtl/lsu_store_buffer.sv
// LSU front end: store FIFO with load forwarding, load-miss read port, oldest-first
// store drain into the cache write port, and flush sequencing with full write-back.
module lsu_store_buffer #(
   parameter int unsigned SB_DEPTH      = 4,
   parameter int unsigned SB_PTR_W      = 2,
   parameter int unsigned WB_MIN_CYCLES = 16
) (
   input logic               clk,
   input logic               reset,
   lsu_store_buffer_if.slave bus
);

   typedef logic [SB_PTR_W-1:0] ptr_t;
   typedef logic [SB_PTR_W:0]   cnt_t;

   typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT, R_GAP}  rd_state_e;
   typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_WAIT, W_GAP}  wr_state_e;
   typedef enum logic [1:0] {F_IDLE, F_DRAIN, F_WB, F_DONE}   fl_state_e;

   localparam cnt_t SB_FULL = cnt_t'(SB_DEPTH);

   rd_state_e   rd_state_q, rd_state_d;
   wr_state_e   wr_state_q, wr_state_d;
   fl_state_e   fl_state_q, fl_state_d;

   ptr_t        head_q, head_d;
   ptr_t        tail_q, tail_d;
   cnt_t        count_q, count_d;

   logic        resp_valid_q, resp_valid_d;
   logic [31:0] resp_data_q, resp_data_d;
   logic [31:0] rd_ptr_q, rd_ptr_d;
   logic        wr_en_q, wr_en_d;
   logic [31:0] wr_ptr_q, wr_ptr_d;
   logic [31:0] wr_val_q, wr_val_d;
   logic        wb_q, wb_d;
   logic [31:0] wb_cnt_q, wb_cnt_d;

   logic [31:0] sb_addr_q [SB_DEPTH];
   logic [31:0] sb_data_q [SB_DEPTH];

   logic        req_ready;
   logic        accept;
   logic        push;
   logic        load_acc;
   logic        pop;
   logic        fwd_hit;
   logic [31:0] fwd_data;
   ptr_t        idx;

   // Reset gates ready combinationally so no request slips in while reset is held.
   assign req_ready = !reset && (rd_state_q == R_IDLE) && (fl_state_q == F_IDLE) &&
                      !(bus.req_store && (count_q == SB_FULL));
   assign accept    = bus.req_valid && req_ready;
   assign push      = accept && bus.req_store;
   assign load_acc  = accept && !bus.req_store;

   // Entry storage carries no reset; validity is defined solely by head/count.
   always_ff @(posedge clk) begin
      if (push) begin
         sb_addr_q[tail_q] <= bus.req_addr;
         sb_data_q[tail_q] <= bus.req_wdata;
      end
   end

   always_comb begin
      rd_state_d   = rd_state_q;
      wr_state_d   = wr_state_q;
      fl_state_d   = fl_state_q;
      resp_valid_d = 1'b0;
      resp_data_d  = resp_data_q;
      rd_ptr_d     = rd_ptr_q;
      wr_en_d      = wr_en_q;
      wr_ptr_d     = wr_ptr_q;
      wr_val_d     = wr_val_q;
      wb_d         = wb_q;
      wb_cnt_d     = wb_cnt_q;
      pop          = 1'b0;
      fwd_hit      = 1'b0;
      fwd_data     = '0;
      idx          = '0;

      // Walk oldest to youngest so the last match seen is the youngest store.
      for (int unsigned i = 0; i < SB_DEPTH; i++) begin
         idx = head_q + ptr_t'(i);
         if ((cnt_t'(i) < count_q) && (sb_addr_q[idx] == bus.req_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = sb_data_q[idx];
         end
      end

      case (rd_state_q)
         R_IDLE: begin
            if (load_acc) begin
               if (fwd_hit) begin
                  resp_valid_d = 1'b1;
                  resp_data_d  = fwd_data;
               end else begin
                  rd_ptr_d   = bus.req_addr;
                  rd_state_d = R_ISSUE;
               end
            end
         end
         R_ISSUE: rd_state_d = R_WAIT;
         R_WAIT: begin
            if (bus.c_read_success) begin
               resp_valid_d = 1'b1;
               resp_data_d  = bus.c_read_value;
               rd_ptr_d     = 'x;
               rd_state_d   = R_GAP;
            end
         end
         R_GAP:   rd_state_d = R_IDLE;
         default: rd_state_d = R_IDLE;
      endcase

      case (wr_state_q)
         W_IDLE: begin
            if (count_q != '0) begin
               wr_ptr_d   = sb_addr_q[head_q];
               wr_val_d   = sb_data_q[head_q];
               wr_en_d    = 1'b1;
               wr_state_d = W_ISSUE;
            end
         end
         W_ISSUE: wr_state_d = W_WAIT;
         W_WAIT: begin
            if (bus.c_write_success) begin
               pop        = 1'b1;
               wr_en_d    = 1'b0;
               wr_state_d = W_GAP;
            end
         end
         W_GAP:   wr_state_d = W_IDLE;
         default: wr_state_d = W_IDLE;
      endcase

      case (fl_state_q)
         F_IDLE: begin
            if (bus.flush) fl_state_d = F_DRAIN;
         end
         F_DRAIN: begin
            if ((count_q == '0) && (wr_state_q == W_IDLE) && (rd_state_q == R_IDLE)) begin
               wb_d       = 1'b1;
               wb_cnt_d   = '0;
               fl_state_d = F_WB;
            end
         end
         F_WB: begin
            // wb_cnt_q counts cycles already spent with allWriteBack high.
            if ((wb_cnt_q >= WB_MIN_CYCLES - 1) && bus.c_all_write_back_success) begin
               wb_d       = 1'b0;
               fl_state_d = F_DONE;
            end else if (wb_cnt_q < WB_MIN_CYCLES - 1) begin
               wb_cnt_d = wb_cnt_q + 32'd1;
            end
         end
         F_DONE:  fl_state_d = F_IDLE;
         default: fl_state_d = F_IDLE;
      endcase

      head_d  = head_q + ptr_t'(pop);
      tail_d  = tail_q + ptr_t'(push);
      count_d = count_q + cnt_t'(push) - cnt_t'(pop);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_state_q   <= R_IDLE;
         wr_state_q   <= W_IDLE;
         fl_state_q   <= F_IDLE;
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         rd_ptr_q     <= 'x;
         wr_en_q      <= 1'b0;
         wr_ptr_q     <= '0;
         wr_val_q     <= '0;
         wb_q         <= 1'b0;
         wb_cnt_q     <= '0;
      end else begin
         rd_state_q   <= rd_state_d;
         wr_state_q   <= wr_state_d;
         fl_state_q   <= fl_state_d;
         head_q       <= head_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_en_q      <= wr_en_d;
         wr_ptr_q     <= wr_ptr_d;
         wr_val_q     <= wr_val_d;
         wb_q         <= wb_d;
         wb_cnt_q     <= wb_cnt_d;
      end
   end

   assign bus.req_ready        = req_ready;
   assign bus.resp_valid       = resp_valid_q;
   assign bus.resp_data        = resp_data_q;
   assign bus.flush_done       = (fl_state_q == F_DONE);
   assign bus.sb_count         = count_q;
   assign bus.c_read_ptr       = rd_ptr_q;
   assign bus.c_write_enable   = wr_en_q;
   assign bus.c_write_ptr      = wr_ptr_q;
   assign bus.c_write_value    = wr_val_q;
   assign bus.c_all_write_back = wb_q;

endmodule

// File: tb/tb_lsu_store_buffer.sv
// Directed bench for lsu_store_buffer: forwarding, misses, drain ordering, flush, reset.
module tb_lsu_store_buffer;
   logic clk = 1'b0;
   logic reset;

   int n_cmp  = 0;
   int n_err  = 0;
   int wr_n   = 0;
   int resp_n = 0;
   int wb_hi_n = 0;
   int fd_n   = 0;
   logic [31:0] wr_ptr_log [16];
   logic [31:0] wr_val_log [16];
   logic        we_prev = 1'b0;

   int base_wr, base_resp, base_wb, base_fd;

   lsu_store_buffer_if #(.SB_PTR_W(2)) bus_if ();

   lsu_store_buffer #(
      .SB_DEPTH(4),
      .SB_PTR_W(2),
      .WB_MIN_CYCLES(16)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus_if.slave)
   );

   always #5 clk = ~clk;

   // Observe cache-side activity mid-cycle: write enable rising edges, pulses, hold time.
   always @(negedge clk) begin
      if (bus_if.c_write_enable && !we_prev) begin
         if (wr_n < 16) begin
            wr_ptr_log[wr_n] = bus_if.c_write_ptr;
            wr_val_log[wr_n] = bus_if.c_write_value;
         end
         wr_n++;
      end
      we_prev = bus_if.c_write_enable;
      if (bus_if.resp_valid)       resp_n++;
      if (bus_if.c_all_write_back) wb_hi_n++;
      if (bus_if.flush_done)       fd_n++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic st, input logic [31:0] a, input logic [31:0] d);
      bus_if.req_valid = v;
      bus_if.req_store = st;
      bus_if.req_addr  = a;
      bus_if.req_wdata = d;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      bus_if.flush                    = 1'b0;
      bus_if.c_read_value             = 32'h0;
      bus_if.c_read_success           = 1'b0;
      bus_if.c_write_success          = 1'b0;
      bus_if.c_all_write_back_success = 1'b0;
      tick();
      tick();
      chk("rst_req_ready",  {31'b0, bus_if.req_ready}, 32'd0);
      chk("rst_resp_valid", {31'b0, bus_if.resp_valid}, 32'd0);
      chk("rst_resp_data",  bus_if.resp_data, 32'h0);
      chk("rst_flush_done", {31'b0, bus_if.flush_done}, 32'd0);
      chk("rst_sb_count",   {29'b0, bus_if.sb_count}, 32'd0);
      chk("rst_wr_en",      {31'b0, bus_if.c_write_enable}, 32'd0);
      chk("rst_wr_ptr",     bus_if.c_write_ptr, 32'h0);
      chk("rst_wr_val",     bus_if.c_write_value, 32'h0);
      chk("rst_all_wb",     {31'b0, bus_if.c_all_write_back}, 32'd0);
      reset = 1'b0;

      // Load miss to 0x20 with a minimum-latency cache.
      bus_if.c_read_value   = 32'h1234;
      bus_if.c_read_success = 1'b1;
      drive(1'b1, 1'b0, 32'h20, 32'h0);
      #1;
      chk("t1_ready", {31'b0, bus_if.req_ready}, 32'd1);
      tick();
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      chk("t1_rd_ptr_issue", bus_if.c_read_ptr, 32'h20);
      chk("t1_no_resp_issue", {31'b0, bus_if.resp_valid}, 32'd0);
      tick();
      chk("t1_rd_ptr_wait", bus_if.c_read_ptr, 32'h20);
      chk("t1_no_resp_wait", {31'b0, bus_if.resp_valid}, 32'd0);
      tick();
      chk("t1_resp_valid", {31'b0, bus_if.resp_valid}, 32'd1);
      chk("t1_resp_data", bus_if.resp_data, 32'h1234);
      chk("t1_rd_ptr_released", {31'b0, (bus_if.c_read_ptr !== 32'h20)}, 32'd1);
      tick();
      chk("t1_resp_pulse_end", {31'b0, bus_if.resp_valid}, 32'd0);
      bus_if.c_read_success = 1'b0;
      tick();

      // Two stores to 0x40, forwarded load returns the younger data.
      base_wr = wr_n;
      drive(1'b1, 1'b1, 32'h40, 32'hAAAA);
      tick();
      drive(1'b1, 1'b1, 32'h40, 32'hBBBB);
      tick();
      drive(1'b1, 1'b0, 32'h40, 32'h0);
      #1;
      chk("t2_load_ready", {31'b0, bus_if.req_ready}, 32'd1);
      tick();
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      chk("t2_fwd_valid", {31'b0, bus_if.resp_valid}, 32'd1);
      chk("t2_fwd_data", bus_if.resp_data, 32'hBBBB);
      chk("t2_count2", {29'b0, bus_if.sb_count}, 32'd2);
      chk("t2_wr_en", {31'b0, bus_if.c_write_enable}, 32'd1);
      chk("t2_wr_val_head", bus_if.c_write_value, 32'hAAAA);
      #1;
      chk("t2_no_cache_read", {31'b0, bus_if.req_ready}, 32'd1);
      bus_if.c_write_success = 1'b1;
      tick();
      chk("t2_count1", {29'b0, bus_if.sb_count}, 32'd1);
      chk("t2_wr_en_drop", {31'b0, bus_if.c_write_enable}, 32'd0);
      for (int k = 0; k < 8; k++) tick();
      chk("t2_count0", {29'b0, bus_if.sb_count}, 32'd0);
      chk("t2_wr_edges", wr_n - base_wr, 32'd2);
      chk("t2_wr0_ptr", wr_ptr_log[base_wr], 32'h40);
      chk("t2_wr0_val", wr_val_log[base_wr], 32'hAAAA);
      chk("t2_wr1_ptr", wr_ptr_log[base_wr + 1], 32'h40);
      chk("t2_wr1_val", wr_val_log[base_wr + 1], 32'hBBBB);

      // Fill the buffer while the cache stalls writes.
      bus_if.c_write_success = 1'b0;
      base_wr = wr_n;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b1, 32'h100 + 32'(i), 32'hD0 + 32'(i));
         tick();
      end
      drive(1'b1, 1'b1, 32'h104, 32'hD4);
      #1;
      chk("t3_count_full", {29'b0, bus_if.sb_count}, 32'd4);
      chk("t3_store_blocked", {31'b0, bus_if.req_ready}, 32'd0);
      bus_if.c_read_value   = 32'h5555;
      bus_if.c_read_success = 1'b1;
      drive(1'b1, 1'b0, 32'h200, 32'h0);
      #1;
      chk("t3_load_ready", {31'b0, bus_if.req_ready}, 32'd1);
      tick();
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      chk("t3_rd_ptr", bus_if.c_read_ptr, 32'h200);
      tick();
      tick();
      chk("t3_resp_valid", {31'b0, bus_if.resp_valid}, 32'd1);
      chk("t3_resp_data", bus_if.resp_data, 32'h5555);
      chk("t3_count_still_full", {29'b0, bus_if.sb_count}, 32'd4);
      bus_if.c_read_success  = 1'b0;
      bus_if.c_write_success = 1'b1;
      for (int k = 0; k < 20; k++) tick();
      chk("t3_drained", {29'b0, bus_if.sb_count}, 32'd0);
      chk("t3_wr_edges", wr_n - base_wr, 32'd4);
      chk("t3_wr_first_ptr", wr_ptr_log[base_wr], 32'h100);
      chk("t3_wr_last_ptr", wr_ptr_log[base_wr + 3], 32'h103);
      chk("t3_wr_last_val", wr_val_log[base_wr + 3], 32'hD3);

      // Back-to-back misses to the same address need an X gap between them.
      base_resp = resp_n;
      bus_if.c_read_value   = 32'h77;
      bus_if.c_read_success = 1'b1;
      drive(1'b1, 1'b0, 32'h10, 32'h0);
      tick();
      chk("t4_ptr_first", bus_if.c_read_ptr, 32'h10);
      tick();
      tick();
      chk("t4_resp1_valid", {31'b0, bus_if.resp_valid}, 32'd1);
      chk("t4_resp1_data", bus_if.resp_data, 32'h77);
      chk("t4_gap1", {31'b0, (bus_if.c_read_ptr !== 32'h10)}, 32'd1);
      bus_if.c_read_value = 32'h88;
      tick();
      chk("t4_gap2", {31'b0, (bus_if.c_read_ptr !== 32'h10)}, 32'd1);
      chk("t4_resp1_end", {31'b0, bus_if.resp_valid}, 32'd0);
      tick();
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      chk("t4_ptr_second", bus_if.c_read_ptr, 32'h10);
      tick();
      tick();
      chk("t4_resp2_valid", {31'b0, bus_if.resp_valid}, 32'd1);
      chk("t4_resp2_data", bus_if.resp_data, 32'h88);
      tick();
      tick();
      chk("t4_resp_pulses", resp_n - base_resp, 32'd2);
      bus_if.c_read_success = 1'b0;

      // Flush with two buffered stores.
      bus_if.c_write_success = 1'b0;
      base_wr = wr_n;
      drive(1'b1, 1'b1, 32'h300, 32'h1);
      tick();
      drive(1'b1, 1'b1, 32'h304, 32'h2);
      tick();
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      bus_if.flush = 1'b1;
      tick();
      bus_if.flush = 1'b0;
      drive(1'b1, 1'b0, 32'h700, 32'h0);
      #1;
      chk("t5_ready_blocked", {31'b0, bus_if.req_ready}, 32'd0);
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      base_wb = wb_hi_n;
      base_fd = fd_n;
      bus_if.c_write_success          = 1'b1;
      bus_if.c_all_write_back_success = 1'b1;
      for (int k = 0; k < 80 && fd_n == base_fd; k++) tick();
      tick();
      tick();
      chk("t5_flush_done_once", fd_n - base_fd, 32'd1);
      chk("t5_wb_min_hold", {31'b0, ((wb_hi_n - base_wb) >= 16)}, 32'd1);
      chk("t5_wr_edges", wr_n - base_wr, 32'd2);
      chk("t5_count0", {29'b0, bus_if.sb_count}, 32'd0);
      chk("t5_all_wb_low", {31'b0, bus_if.c_all_write_back}, 32'd0);
      drive(1'b1, 1'b1, 32'h0, 32'h0);
      #1;
      chk("t5_ready_again", {31'b0, bus_if.req_ready}, 32'd1);
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      bus_if.c_all_write_back_success = 1'b0;
      tick();

      // Reset during R_WAIT with three stores pending.
      bus_if.c_write_success = 1'b0;
      bus_if.c_read_success  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 32'h500 + 32'(4 * i), 32'hE0 + 32'(i));
         tick();
      end
      drive(1'b1, 1'b0, 32'h600, 32'h0);
      tick();
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      chk("t6_in_wait", bus_if.c_read_ptr, 32'h600);
      chk("t6_count3", {29'b0, bus_if.sb_count}, 32'd3);
      #3;
      reset = 1'b1;
      #1;
      chk("t6_rst_count", {29'b0, bus_if.sb_count}, 32'd0);
      chk("t6_rst_ready", {31'b0, bus_if.req_ready}, 32'd0);
      chk("t6_rst_wr_en", {31'b0, bus_if.c_write_enable}, 32'd0);
      chk("t6_rst_wr_ptr", bus_if.c_write_ptr, 32'h0);
      chk("t6_rst_resp_data", bus_if.resp_data, 32'h0);
      chk("t6_rst_rd_ptr", {31'b0, (bus_if.c_read_ptr !== 32'h600)}, 32'd1);
      base_wr   = wr_n;
      base_resp = resp_n;
      bus_if.c_read_value    = 32'h99;
      bus_if.c_read_success  = 1'b1;
      bus_if.c_write_success = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      for (int k = 0; k < 10; k++) tick();
      chk("t6_no_resp", resp_n - base_resp, 32'd0);
      chk("t6_no_writes", wr_n - base_wr, 32'd0);
      chk("t6_count_after", {29'b0, bus_if.sb_count}, 32'd0);
      chk("t6_resp_data_after", bus_if.resp_data, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
